vga_stream_timing: RTL and testbench
====================================

Name: vga_stream_timing

Overview:
- Parametrised successor to the fixed 800x480 VGA generator.
- Every timing field, both sync polarities and the colour width are parameters.
- Single-clock pixel domain: reads pixels from a show-ahead source (async FIFO read side) and drives video_if-style HS/VS/BLANK/RGB.
- Adds a frame-aligned start/underrun-recovery state machine, a source flush request and a saturating underrun counter.

Parameters:
- HDISP, 800, active pixels per line
- VDISP, 480, active lines per frame
- HFP / HPULSE / HBP, 40 / 48 / 40, horizontal front porch / sync width / back porch
- VFP / VPULSE / VBP, 13 / 3 / 29, vertical front porch / sync width / back porch
- HS_POL, 0, HS level during sync pulse (0 = active low)
- VS_POL, 0, VS level during sync pulse
- RGB_W, 24, pixel width
- CNT_W, 16, underrun counter width

Ports:
- pixel_clk  in  1  pixel clock
- pixel_rst  in  1  asynchronous, active-high reset
- src_data  in  RGB_W  show-ahead pixel; valid whenever src_empty=0
- src_empty  in  1  source has no pixel
- src_ready  in  1  source primed with a frame starting at address 0
- src_rd  out  1  pop strobe (combinational)
- src_flush  out  1  one-cycle pulse: source must discard contents and restart at frame address 0
- HS  out  1  horizontal sync, polarity HS_POL
- VS  out  1  vertical sync, polarity VS_POL
- BLANK  out  1  1 = active video (codebase convention)
- RGB  out  RGB_W  pixel colour
- frame_start  out  1  pulse aligned with first active pixel on outputs
- running  out  1  state==RUN
- underrun_cnt  out  CNT_W  saturating underrun event count

Behaviour:
- HTOTAL = HDISP+HFP+HPULSE+HBP; VTOTAL = VDISP+VFP+VPULSE+VBP.
- px width is $clog2(HTOTAL); py width is $clog2(VTOTAL).
- Counters:
  - px increments every cycle and wraps HTOTAL-1 -> 0.
  - On px wrap, py increments and wraps VTOTAL-1 -> 0.
  - Reset: px=py=0.
- active = (px<HDISP && py<VDISP).
- frame_end = (px==HTOTAL-1 && py==VTOTAL-1).
- Outputs are registered with 1-cycle latency from (px,py), all aligned:
  - HS = HS_POL when HDISP+HFP <= px < HDISP+HFP+HPULSE, else !HS_POL.
  - VS: same rule on py with VDISP/VFP/VPULSE/VS_POL.
  - BLANK <= active.
  - frame_start <= (px==0 && py==0 && state==RUN).
- Reset values: HS=!HS_POL, VS=!VS_POL, BLANK=0, RGB=0, frame_start=0, src_flush=0, underrun_cnt=0, state=IDLE.
- FSM states: IDLE, RUN, RESYNC.
  - IDLE: src_rd=0. On frame_end && src_ready -> RUN, so the first pop happens at (0,0).
  - RUN: src_rd = active && !src_empty; RGB <= src_data when src_rd, else 0.
  - RUN underrun (active && src_empty):
    - src_rd=0 and RGB <= 0.
    - underrun_cnt +1, saturating at all-ones.
    - src_flush=1 on the next cycle (registered).
    - -> RESYNC.
  - RESYNC: src_rd=0 and RGB=0 for the rest of the frame. On frame_end: -> RUN if src_ready, else -> IDLE.
- Outside active, RGB <= 0 in every state.
- Simultaneous events:
  - Underrun on the last active pixel still enters RESYNC.
  - frame_end in RESYNC is evaluated after entry; no early exit.
- Reset mid-frame returns counters and FSM to reset values immediately (async); outputs go to reset values with no glitch cycle.
- running is a register mirroring state==RUN.

Optional Feature:
- Macro VGA_TEST_PATTERN_EN.
- Defined: in IDLE and RESYNC, active pixels show 8 vertical colour bars of width HDISP/8 (order white, yellow, cyan, green, magenta, red, blue, black; each channel all-ones or 0) instead of black. RUN is unchanged.
- Undefined: those pixels are 0, and no bar logic is built.

Test Plan:
Common parameters: HDISP=8, VDISP=4, HFP=2, HPULSE=2, HBP=2, VFP=1, VPULSE=1, VBP=1, HTOTAL=14, VTOTAL=7.
1. Reset then free-run, src_ready=0 -> HS low exactly at px 10..11 (outputs seen one cycle later); VS low for line 5; BLANK high for 32 cycles per 98-cycle frame; src_rd never high.
2. src_ready=1, source full of values 0..31 -> RUN from the second frame; frame_start pulses once per frame; RGB shows 0..31 in raster order; exactly 32 pops per frame.
3. src_empty forced high at pixel (3,1) -> RGB=0 there; underrun_cnt=1; src_flush pulses once; no pops for the rest of the frame; next frame starts at value 0 in RUN.
4. Underrun with src_ready=0 at frame_end -> IDLE; running=0; resumes at the first frame_end with src_ready=1.
5. CNT_W=2, underrun every frame for 5 frames -> underrun_cnt saturates at 3.
6. pixel_rst asserted at (5,2) during RUN -> outputs at reset values the same cycle; state IDLE; counters at 0 after release. With VGA_TEST_PATTERN_EN, pixel x=2 in IDLE = cyan (0x00FFFF).

Source files
------------

// File: rtl/vga_stream_timing.sv
// vga_stream_timing: parametrised raster timing generator fed by a show-ahead
// pixel source. It waits for a frame-aligned start, recovers from source
// underruns at the next frame boundary, and counts underrun events.
// Optional build macro: VGA_TEST_PATTERN_EN shows eight vertical colour bars
// on active pixels while the stream is not running (IDLE / RESYNC).
module vga_stream_timing #(
  parameter int HDISP  = 800,
  parameter int VDISP  = 480,
  parameter int HFP    = 40,
  parameter int HPULSE = 48,
  parameter int HBP    = 40,
  parameter int VFP    = 13,
  parameter int VPULSE = 3,
  parameter int VBP    = 29,
  parameter bit HS_POL = 1'b0,
  parameter bit VS_POL = 1'b0,
  parameter int RGB_W  = 24,
  parameter int CNT_W  = 16
) (
  input  logic             pixel_clk,
  input  logic             pixel_rst,
  input  logic [RGB_W-1:0] src_data,
  input  logic             src_empty,
  input  logic             src_ready,
  output logic             src_rd,
  output logic             src_flush,
  output logic             HS,
  output logic             VS,
  output logic             BLANK,
  output logic [RGB_W-1:0] RGB,
  output logic             frame_start,
  output logic             running,
  output logic [CNT_W-1:0] underrun_cnt
);

  localparam int HTOTAL = HDISP + HFP + HPULSE + HBP;
  localparam int VTOTAL = VDISP + VFP + VPULSE + VBP;
  localparam int PX_W   = $clog2(HTOTAL);
  localparam int PY_W   = $clog2(VTOTAL);

  // Timing boundaries pre-sized to the counter widths.
  localparam logic [PX_W-1:0] X_ONE  = PX_W'(1);
  localparam logic [PX_W-1:0] X_ACT  = PX_W'(HDISP);
  localparam logic [PX_W-1:0] X_HS0  = PX_W'(HDISP + HFP);
  localparam logic [PX_W-1:0] X_HS1  = PX_W'(HDISP + HFP + HPULSE);
  localparam logic [PX_W-1:0] X_LAST = PX_W'(HTOTAL - 1);
  localparam logic [PY_W-1:0] Y_ONE  = PY_W'(1);
  localparam logic [PY_W-1:0] Y_ACT  = PY_W'(VDISP);
  localparam logic [PY_W-1:0] Y_VS0  = PY_W'(VDISP + VFP);
  localparam logic [PY_W-1:0] Y_VS1  = PY_W'(VDISP + VFP + VPULSE);
  localparam logic [PY_W-1:0] Y_LAST = PY_W'(VTOTAL - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_RESYNC = 2'd2
  } state_t;

  logic [PX_W-1:0]  r_px;
  logic [PY_W-1:0]  r_py;
  state_t           r_state;
  state_t           w_state_nx;
  logic             w_active;
  logic             w_frame_end;
  logic             w_hsync;
  logic             w_vsync;
  logic             w_src_rd;
  logic             w_underrun;
  logic [RGB_W-1:0] w_fill;
  logic [RGB_W-1:0] w_rgb_nx;

  logic             r_hs;
  logic             r_vs;
  logic             r_blank;
  logic [RGB_W-1:0] r_rgb;
  logic             r_frame_start;
  logic             r_flush;
  logic             r_running;
  logic [CNT_W-1:0] r_cnt;

  assign w_active    = (r_px < X_ACT) && (r_py < Y_ACT);
  assign w_frame_end = (r_px == X_LAST) && (r_py == Y_LAST);
  assign w_hsync     = (r_px >= X_HS0) && (r_px < X_HS1);
  assign w_vsync     = (r_py >= Y_VS0) && (r_py < Y_VS1);

  // Raster position: px runs every cycle, py advances on px wrap.
  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      r_px <= {PX_W{1'b0}};
      r_py <= {PY_W{1'b0}};
    end else if (r_px == X_LAST) begin
      r_px <= {PX_W{1'b0}};
      if (r_py == Y_LAST) begin
        r_py <= {PY_W{1'b0}};
      end else begin
        r_py <= r_py + Y_ONE;
      end
    end else begin
      r_px <= r_px + X_ONE;
    end
  end

  // Stream state register.
  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Next-state, pop strobe and underrun detection. Entering RUN only at
  // frame_end guarantees the first pop lands on pixel (0,0).
  always_comb begin
    w_state_nx = r_state;
    w_src_rd   = 1'b0;
    w_underrun = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_frame_end && src_ready) begin
          w_state_nx = S_RUN;
        end else begin
          w_state_nx = S_IDLE;
        end
      end
      S_RUN: begin
        if (w_active && src_empty) begin
          w_underrun = 1'b1;
          w_state_nx = S_RESYNC;
        end else begin
          w_src_rd   = w_active;
          w_state_nx = S_RUN;
        end
      end
      S_RESYNC: begin
        if (w_frame_end) begin
          w_state_nx = src_ready ? S_RUN : S_IDLE;
        end else begin
          w_state_nx = S_RESYNC;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  assign src_rd = w_src_rd;

`ifdef VGA_TEST_PATTERN_EN
  localparam int CH_W  = RGB_W / 3;
  localparam int BAR_N = (HDISP / 8 > 0) ? (HDISP / 8) : 1;
  localparam logic [PX_W-1:0] X_BAR  = PX_W'(BAR_N);
  localparam logic [PX_W-1:0] X_BMAX = PX_W'(7);

  logic [PX_W-1:0] w_bar_q;
  logic [2:0]      w_bar_idx;

  // Bar index to colour: white, yellow, cyan, green, magenta, red, blue, black.
  function automatic logic [RGB_W-1:0] bar_color(input logic [2:0] idx);
    logic [2:0] v_rgb;
    case (idx)
      3'd0:    v_rgb = 3'b111;
      3'd1:    v_rgb = 3'b110;
      3'd2:    v_rgb = 3'b011;
      3'd3:    v_rgb = 3'b010;
      3'd4:    v_rgb = 3'b101;
      3'd5:    v_rgb = 3'b100;
      3'd6:    v_rgb = 3'b001;
      default: v_rgb = 3'b000;
    endcase
    return RGB_W'({{CH_W{v_rgb[2]}}, {CH_W{v_rgb[1]}}, {CH_W{v_rgb[0]}}});
  endfunction

  assign w_bar_q = r_px / X_BAR;

  // Clamp the bar index so a display width not divisible by 8 stays black.
  always_comb begin
    if (w_bar_q > X_BMAX) begin
      w_bar_idx = 3'd7;
    end else begin
      w_bar_idx = w_bar_q[2:0];
    end
  end

  assign w_fill = bar_color(w_bar_idx);
`else
  assign w_fill = {RGB_W{1'b0}};
`endif

  // Pixel selection: stream data in RUN, fill (black or bars) otherwise.
  always_comb begin
    w_rgb_nx = {RGB_W{1'b0}};
    if (r_state == S_RUN) begin
      if (w_src_rd) begin
        w_rgb_nx = src_data;
      end else begin
        w_rgb_nx = {RGB_W{1'b0}};
      end
    end else if (w_active) begin
      w_rgb_nx = w_fill;
    end else begin
      w_rgb_nx = {RGB_W{1'b0}};
    end
  end

  // Registered video outputs, flush pulse and saturating underrun counter.
  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      r_hs          <= ~HS_POL;
      r_vs          <= ~VS_POL;
      r_blank       <= 1'b0;
      r_rgb         <= {RGB_W{1'b0}};
      r_frame_start <= 1'b0;
      r_flush       <= 1'b0;
      r_running     <= 1'b0;
      r_cnt         <= {CNT_W{1'b0}};
    end else begin
      r_hs          <= w_hsync ? HS_POL : ~HS_POL;
      r_vs          <= w_vsync ? VS_POL : ~VS_POL;
      r_blank       <= w_active;
      r_rgb         <= w_rgb_nx;
      r_frame_start <= (r_px == {PX_W{1'b0}}) && (r_py == {PY_W{1'b0}}) && (r_state == S_RUN);
      r_flush       <= w_underrun;
      r_running     <= (w_state_nx == S_RUN);
      if (w_underrun && (r_cnt != CNT_MAX)) begin
        r_cnt <= r_cnt + CNT_ONE;
      end else begin
        r_cnt <= r_cnt;
      end
    end
  end

  assign HS           = r_hs;
  assign VS           = r_vs;
  assign BLANK        = r_blank;
  assign RGB          = r_rgb;
  assign frame_start  = r_frame_start;
  assign src_flush    = r_flush;
  assign running      = r_running;
  assign underrun_cnt = r_cnt;

endmodule

// File: tb/tb_vga_stream_timing.sv
// Scoreboard bench for vga_stream_timing on a 14x7 raster. A driver issues
// per-cycle stimulus and pushes the reference model's expected response; a
// monitor pops and compares against the DUT outputs.
module tb_vga_stream_timing;

  localparam int HD = 8, VD = 4, HFP = 2, HP = 2, HBP = 2, VFP = 1, VP = 1, VBP = 1;
  localparam int HT = HD + HFP + HP + HBP;   // 14
  localparam int VT = VD + VFP + VP + VBP;   // 7
  localparam int CNT_W = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int M_IDLE = 0, M_RUN = 1, M_RESYNC = 2;

  logic        pixel_clk = 1'b0;
  logic        pixel_rst = 1'b1;
  logic [23:0] src_data = 24'd0;
  logic        src_empty = 1'b0;
  logic        src_ready = 1'b0;
  logic        src_rd, src_flush, HS, VS, BLANK, frame_start, running;
  logic [23:0] RGB;
  logic [CNT_W-1:0] underrun_cnt;

  vga_stream_timing #(
    .HDISP(HD), .VDISP(VD), .HFP(HFP), .HPULSE(HP), .HBP(HBP),
    .VFP(VFP), .VPULSE(VP), .VBP(VBP), .HS_POL(1'b0), .VS_POL(1'b0),
    .RGB_W(24), .CNT_W(CNT_W)
  ) dut (
    .pixel_clk(pixel_clk), .pixel_rst(pixel_rst), .src_data(src_data),
    .src_empty(src_empty), .src_ready(src_ready), .src_rd(src_rd),
    .src_flush(src_flush), .HS(HS), .VS(VS), .BLANK(BLANK), .RGB(RGB),
    .frame_start(frame_start), .running(running), .underrun_cnt(underrun_cnt)
  );

  always #5 pixel_clk = ~pixel_clk;

  typedef struct {
    logic        hs, vs, blank;
    logic [23:0] rgb;
    logic        fs, flush;
    logic [CNT_W-1:0] cnt;
    logic        running;
  } exp_t;

  exp_t exp_q[$];
  bit   rd_q[$];
  int   n_chk = 0;
  int   n_pass = 0;

  // Reference model state: raster position, stream mode, source address.
  int m_px, m_py, m_mode, m_cnt, m_addr;
  // Stimulus settings for the current frame.
  bit g_ready, g_inj, g_noise, g_release;
  int g_ux, g_uy;
  logic [23:0] g_base;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
  endtask

  function automatic logic [23:0] fill_color(input int x);
`ifdef VGA_TEST_PATTERN_EN
    logic [23:0] bars[8];
    bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    return bars[x / (HD / 8)];
`else
    return (x < 0) ? 24'hFFFFFF : 24'h000000;
`endif
  endfunction

  function automatic void model_reset();
    m_px = 0; m_py = 0; m_mode = M_IDLE; m_cnt = 0; m_addr = 0;
  endfunction

  // One pixel-clock of stimulus plus the reference response it implies.
  task automatic step();
    bit act, fe, empty, rd, ur;
    int nm;
    exp_t e;
    if (g_release) begin
      pixel_rst = 1'b0;
      g_release = 1'b0;
    end
    act   = (m_px < HD) && (m_py < VD);
    fe    = (m_px == HT - 1) && (m_py == VT - 1);
    empty = (g_inj && m_px == g_ux && m_py == g_uy) ||
            (g_noise && (!act || m_mode != M_RUN) && $urandom_range(0, 2) == 0);
    src_empty = empty;
    src_ready = g_ready;
    src_data  = g_base | 24'(m_addr);
    rd = (m_mode == M_RUN) && act && !empty;
    ur = (m_mode == M_RUN) && act && empty;
    nm = m_mode;
    if (m_mode == M_IDLE && fe && g_ready) nm = M_RUN;
    if (ur) nm = M_RESYNC;
    if (m_mode == M_RESYNC && fe) nm = g_ready ? M_RUN : M_IDLE;
    e.hs    = !((m_px >= HD + HFP) && (m_px < HD + HFP + HP));
    e.vs    = !((m_py >= VD + VFP) && (m_py < VD + VFP + VP));
    e.blank = act;
    e.rgb   = rd ? (g_base | 24'(m_addr)) : ((m_mode != M_RUN && act) ? fill_color(m_px) : 24'h0);
    e.fs    = (m_px == 0) && (m_py == 0) && (m_mode == M_RUN);
    e.flush = ur;
    if (ur && m_cnt < CNT_MAX) m_cnt++;
    e.cnt     = CNT_W'(m_cnt);
    e.running = (nm == M_RUN);
    exp_q.push_back(e);
    rd_q.push_back(rd);
    if (ur) m_addr = 0;
    else if (rd) m_addr = (m_addr + 1) % (HD * VD);
    m_mode = nm;
    m_px = m_px + 1;
    if (m_px == HT) begin
      m_px = 0;
      m_py = (m_py + 1) % VT;
    end
  endtask

  task automatic run_frames(input int n);
    for (int i = 0; i < n * HT * VT; i++) begin
      @(negedge pixel_clk);
      step();
    end
  endtask

  task automatic check_reset_values();
    chk("rst_HS", 32'(HS), 32'd1);
    chk("rst_VS", 32'(VS), 32'd1);
    chk("rst_BLANK", 32'(BLANK), 32'd0);
    chk("rst_RGB", 32'(RGB), 32'd0);
    chk("rst_frame_start", 32'(frame_start), 32'd0);
    chk("rst_src_flush", 32'(src_flush), 32'd0);
    chk("rst_underrun_cnt", 32'(underrun_cnt), 32'd0);
    chk("rst_running", 32'(running), 32'd0);
    chk("rst_src_rd", 32'(src_rd), 32'd0);
  endtask

  // Monitor: registered outputs just after each active edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge pixel_clk);
      #1;
      if (!pixel_rst && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("HS", 32'(HS), 32'(e.hs));
        chk("VS", 32'(VS), 32'(e.vs));
        chk("BLANK", 32'(BLANK), 32'(e.blank));
        chk("RGB", 32'(RGB), 32'(e.rgb));
        chk("frame_start", 32'(frame_start), 32'(e.fs));
        chk("src_flush", 32'(src_flush), 32'(e.flush));
        chk("underrun_cnt", 32'(underrun_cnt), 32'(e.cnt));
        chk("running", 32'(running), 32'(e.running));
      end
    end
  end

  // Monitor: combinational pop strobe once the driver has set the inputs.
  initial begin
    bit r;
    forever begin
      @(negedge pixel_clk);
      #2;
      if (!pixel_rst && rd_q.size() > 0) begin
        r = rd_q.pop_front();
        chk("src_rd", 32'(src_rd), 32'(r));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    g_ready = 1'b0; g_inj = 1'b0; g_noise = 1'b0; g_ux = 0; g_uy = 0;
    g_base = 24'h0; g_release = 1'b0;
    repeat (3) @(negedge pixel_clk);
    #1;
    check_reset_values();
    g_release = 1'b1;

    // Free-run with no source: sync timing only, no pops.
    run_frames(2);
    // Source primed with 0..31: RUN from the next frame.
    g_ready = 1'b1;
    run_frames(3);
    // Single underrun at pixel (3,1), recovery into RUN.
    g_inj = 1'b1; g_ux = 3; g_uy = 1;
    run_frames(1);
    g_inj = 1'b0;
    run_frames(2);
    // Underrun with source not ready at frame end: drop to IDLE, then resume.
    g_inj = 1'b1; g_ux = 7; g_uy = 3; g_ready = 1'b0;
    run_frames(1);
    g_inj = 1'b0;
    run_frames(1);
    g_ready = 1'b1;
    run_frames(2);
    // Underrun every frame: counter saturates.
    g_inj = 1'b1; g_ux = 0; g_uy = 0;
    run_frames(5);
    g_inj = 1'b0;
    run_frames(1);
    // Asynchronous reset at (5,2) while running.
    while (!(m_px == 5 && m_py == 2)) begin
      @(negedge pixel_clk);
      step();
    end
    @(negedge pixel_clk);
    pixel_rst = 1'b1;
    exp_q.delete();
    rd_q.delete();
    #1;
    check_reset_values();
    model_reset();
    g_ready = 1'b0;
    repeat (2) @(negedge pixel_clk);
    g_release = 1'b1;
    run_frames(1);
    g_ready = 1'b1;
    run_frames(2);
    // Randomised frames: readiness, underrun position, empty noise, data base.
    g_noise = 1'b1;
    for (int f = 0; f < 20; f++) begin
      g_ready = ($urandom_range(0, 3) != 0);
      g_inj   = ($urandom_range(0, 2) == 0);
      g_ux    = $urandom_range(0, HD - 1);
      g_uy    = $urandom_range(0, VD - 1);
      g_base  = 24'($urandom) & 24'hFFFFE0;
      run_frames(1);
    end
    @(posedge pixel_clk);
    #3;
    chk("queues_drained", 32'(exp_q.size() + rd_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
